// File: rtl/rv_pending_arbiter_if.sv
// Request/completion bus between the requesters, the pending arbiter and
// the shared memory port. The arbiter sits on the slave side. Whatever
// drives the requesters and the memory port sits on the master side.
interface rv_pending_arbiter_if #(
   parameter int NUM_REQS = 4,
   parameter int REQW     = 2
);
   logic [NUM_REQS-1:0] req_valid;
   logic [NUM_REQS-1:0] req_ready;
   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [REQW-1:0]     mem_req_id;
   logic                mem_rsp_valid;
   logic [REQW-1:0]     mem_rsp_id;
   logic                mem_rsp_ready;
   logic [NUM_REQS-1:0] rsp_valid;

   modport slave (
      input  req_valid,
      input  mem_req_ready,
      input  mem_rsp_valid,
      input  mem_rsp_id,
      output req_ready,
      output mem_req_valid,
      output mem_req_id,
      output mem_rsp_ready,
      output rsp_valid
   );

   modport master (
      output req_valid,
      output mem_req_ready,
      output mem_rsp_valid,
      output mem_rsp_id,
      input  req_ready,
      input  mem_req_valid,
      input  mem_req_id,
      input  mem_rsp_ready,
      input  rsp_valid
   );
endinterface

// File: rtl/rv_pending_arbiter.sv
// Round-robin arbiter that shares one memory request port among NUM_REQS
// requesters. It keeps at most SIZE requests in flight, routes each
// completion back to its requester, and drains outstanding traffic on flush.
module rv_pending_arbiter #(
   parameter int NUM_REQS = 4,
   parameter int SIZE     = 4,
   parameter int REQW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
   parameter int SIZEW    = $clog2(SIZE + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   rv_pending_arbiter_if.slave  bus,
   input  logic                 flush,
   output logic                 flush_done,
   output logic [SIZEW-1:0]     pending_size,
   output logic                 pending_empty,
   output logic                 pending_full,
   output logic                 underflow_err
);

   localparam logic [1:0] STATE_RUN   = 2'd0;
   localparam logic [1:0] STATE_DRAIN = 2'd1;
   localparam logic [1:0] STATE_DONE  = 2'd2;

   logic [1:0]       state;
   logic [SIZEW-1:0] count;
   logic             empty_q;
   logic             full_q;
   logic [REQW-1:0]  ptr;
   logic             underflow_q;

   logic             issue_en;
   logic             any_req;
   logic             grant_found;
   logic [REQW-1:0]  grant_idx;
   logic [REQW-1:0]  ptr_next;
   logic             fire;
   logic             done;

   // Issue depends only on registered state, so completions never reach the
   // request side combinationally.
   assign issue_en = (state == STATE_RUN) && !full_q;
   assign any_req  = |bus.req_valid;
   assign fire     = bus.mem_req_valid && bus.mem_req_ready;
   assign done     = bus.mem_rsp_valid && !empty_q;

   // Find the first valid requester, scanning upward from the round-robin
   // pointer and wrapping at NUM_REQS.
   always_comb begin
      logic [REQW:0]   sum;
      logic [REQW-1:0] cand;
      grant_found = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      cand        = '0;
      for (int k = 0; k < NUM_REQS; k++) begin
         sum = {1'b0, ptr} + (REQW+1)'(k);
         if (sum >= (REQW+1)'(NUM_REQS)) begin
            sum = sum - (REQW+1)'(NUM_REQS);
         end
         cand = sum[REQW-1:0];
         if (!grant_found && bus.req_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign ptr_next = (grant_idx == REQW'(NUM_REQS - 1)) ? '0 : grant_idx + REQW'(1);

   assign bus.mem_req_valid = issue_en && any_req;
   assign bus.mem_req_id    = grant_idx;
   assign bus.req_ready     = (issue_en && bus.mem_req_ready && grant_found)
                              ? (NUM_REQS'(1) << grant_idx) : '0;
   assign bus.mem_rsp_ready = 1'b1;
   assign bus.rsp_valid     = done ? (NUM_REQS'(1) << bus.mem_rsp_id) : '0;

   assign flush_done    = (state == STATE_DONE);
   assign pending_size  = count;
   assign pending_empty = empty_q;
   assign pending_full  = full_q;
   assign underflow_err = underflow_q;

   // The round-robin pointer moves past the winner only when a request
   // actually fires. A stalled grant keeps the same winner.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
      end else if (fire) begin
         ptr <= ptr_next;
      end
   end

   // The outstanding counter keeps empty/full as registered flags.
   // An issue and a completion in the same cycle cancel out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else if (fire && !done) begin
         count   <= count + SIZEW'(1);
         empty_q <= 1'b0;
         full_q  <= (count == SIZEW'(SIZE - 1));
      end else if (done && !fire) begin
         count   <= count - SIZEW'(1);
         full_q  <= 1'b0;
         empty_q <= (count == SIZEW'(1));
      end
   end

   // A completion that arrives with nothing outstanding is dropped and
   // latched as an error until the next reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         underflow_q <= 1'b0;
      end else if (bus.mem_rsp_valid && empty_q) begin
         underflow_q <= 1'b1;
      end
   end

   // Flush sequencing. RUN stops issuing in DRAIN, waits for the counter to
   // empty, then holds DONE until flush is released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= STATE_RUN;
      end else begin
         case (state)
            STATE_RUN: begin
               if (flush) state <= STATE_DRAIN;
            end
            STATE_DRAIN: begin
               if (empty_q) state <= STATE_DONE;
            end
            STATE_DONE: begin
               if (!flush) state <= STATE_RUN;
            end
            default: state <= STATE_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_pending_arbiter.sv
// Self-checking bench for rv_pending_arbiter. A count-based reference model
// predicts grants, completions, occupancy and flush status for each cycle.
// Directed sequences and a randomized run are both checked against it.
module tb_rv_pending_arbiter;
   localparam int NUM_REQS = 4;
   localparam int SIZE     = 4;
   localparam int REQW     = 2;
   localparam int SIZEW    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             flush_done;
   logic [SIZEW-1:0] pending_size;
   logic             pending_empty;
   logic             pending_full;
   logic             underflow_err;

   rv_pending_arbiter_if #(.NUM_REQS(NUM_REQS), .REQW(REQW)) bus();

   rv_pending_arbiter #(
      .NUM_REQS(NUM_REQS),
      .SIZE(SIZE),
      .REQW(REQW),
      .SIZEW(SIZEW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .flush(flush),
      .flush_done(flush_done),
      .pending_size(pending_size),
      .pending_empty(pending_empty),
      .pending_full(pending_full),
      .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model: outstanding count, next requester in line,
   // mode (0 run, 1 draining, 2 drained) and sticky underflow.
   int   mCount;
   int   mPtr;
   int   mMode;
   bit   mUnder;
   int   expGrant;
   bit   expFire;
   bit   stimRspValid;
   bit   stimFlush;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mCount  = 0;
      mPtr    = 0;
      mMode   = 0;
      mUnder  = 1'b0;
      expFire = 1'b0;
   endtask

   // Drive one cycle of inputs, then compare every output with the model
   // at the falling edge.
   task automatic applyStimulus(input logic [3:0] rv, input bit rdy, input bit rspv, input int rspid, input bit fl);
      bit          issueOk;
      bit          found;
      int          g;
      int          idx;
      logic [3:0]  expReady;
      logic [3:0]  expRsp;
      bus.req_valid     = rv;
      bus.mem_req_ready = rdy;
      bus.mem_rsp_valid = rspv;
      bus.mem_rsp_id    = REQW'(rspid);
      flush             = fl;
      stimRspValid      = rspv;
      stimFlush         = fl;
      @(negedge clk);
      issueOk = (mMode == 0) && (mCount < SIZE);
      found = 1'b0;
      g = 0;
      for (int k = 0; k < NUM_REQS; k++) begin
         idx = (mPtr + k) % NUM_REQS;
         if (!found && (((rv >> idx) & 4'd1) != 4'd0)) begin
            found = 1'b1;
            g = idx;
         end
      end
      expGrant = g;
      expFire  = issueOk && found && rdy;
      expReady = expFire ? 4'(1 << g) : 4'b0000;
      expRsp   = (rspv && mCount > 0) ? 4'(1 << rspid) : 4'b0000;
      checkOutput("memReqValid", 32'(bus.mem_req_valid), 32'(issueOk && found));
      if (issueOk && found) checkOutput("memReqId", 32'(bus.mem_req_id), 32'(g));
      checkOutput("reqReady", 32'(bus.req_ready), 32'(expReady));
      checkOutput("rspValid", 32'(bus.rsp_valid), 32'(expRsp));
      checkOutput("memRspReady", 32'(bus.mem_rsp_ready), 32'd1);
      checkOutput("pendingSize", 32'(pending_size), 32'(mCount));
      checkOutput("pendingEmpty", 32'(pending_empty), 32'(mCount == 0));
      checkOutput("pendingFull", 32'(pending_full), 32'(mCount == SIZE));
      checkOutput("flushDone", 32'(flush_done), 32'(mMode == 2));
      checkOutput("underflowErr", 32'(underflow_err), 32'(mUnder));
   endtask

   // Advance through the rising edge and step the model with the pre-edge values.
   task automatic tick();
      bit doneNow;
      doneNow = stimRspValid && (mCount > 0);
      @(posedge clk);
      if (stimRspValid && mCount == 0) mUnder = 1'b1;
      case (mMode)
         0: if (stimFlush) mMode = 1;
         1: if (mCount == 0) mMode = 2;
         2: if (!stimFlush) mMode = 0;
         default: mMode = 0;
      endcase
      if (expFire) begin
         mPtr = (expGrant + 1) % NUM_REQS;
         mCount++;
      end
      if (doneNow) mCount--;
      #1;
   endtask

   task automatic applyReset();
      reset             = 1'b0;
      bus.req_valid     = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_id    = '0;
      flush             = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetSize", 32'(pending_size), 32'd0);
      checkOutput("resetEmpty", 32'(pending_empty), 32'd1);
      checkOutput("resetFull", 32'(pending_full), 32'd0);
      checkOutput("resetFlushDone", 32'(flush_done), 32'd0);
      checkOutput("resetUnderflow", 32'(underflow_err), 32'd0);
      checkOutput("resetMemReqValid", 32'(bus.mem_req_valid), 32'd0);
      checkOutput("resetReqReady", 32'(bus.req_ready), 32'd0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  flushHold;
      bit  gotDone;
      modelReset();
      stimRspValid = 1'b0;
      stimFlush    = 1'b0;
      applyReset();

      // Fill up: grants 0..3, then blocked at full.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'hF, 1'b1, 1'b0, 0, 1'b0);
         checkOutput("fillGrantId", 32'(bus.mem_req_id), 32'(i));
         tick();
      end
      applyStimulus(4'hF, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("fullBlocksValid", 32'(bus.mem_req_valid), 32'd0);
      checkOutput("fullBlocksReady", 32'(bus.req_ready), 32'd0);
      checkOutput("fullFlag", 32'(pending_full), 32'd1);
      tick();

      // One completion for id 2 at full frees a slot. The pointer has wrapped to 0.
      applyStimulus(4'hF, 1'b1, 1'b1, 2, 1'b0);
      checkOutput("rspRouteId2", 32'(bus.rsp_valid), 32'h4);
      tick();
      applyStimulus(4'hF, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("afterRspSize", 32'(pending_size), 32'd3);
      checkOutput("afterRspGrant", 32'(bus.mem_req_id), 32'd0);
      tick();

      // Down to 2, then issue and complete together, then drain to empty.
      applyStimulus(4'h0, 1'b0, 1'b1, 0, 1'b0);
      tick();
      applyStimulus(4'hF, 1'b1, 1'b1, 1, 1'b0);
      tick();
      applyStimulus(4'h0, 1'b0, 1'b1, 3, 1'b0);
      checkOutput("sameCycleSize", 32'(pending_size), 32'd2);
      tick();
      applyStimulus(4'h0, 1'b0, 1'b1, 0, 1'b0);
      tick();
      applyStimulus(4'h0, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("drainedEmpty", 32'(pending_empty), 32'd1);
      tick();

      // A completion with nothing outstanding is dropped and latched.
      applyStimulus(4'h0, 1'b0, 1'b1, 1, 1'b0);
      checkOutput("underflowRsp", 32'(bus.rsp_valid), 32'd0);
      tick();
      applyStimulus(4'h0, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("underflowSet", 32'(underflow_err), 32'd1);
      tick();

      // Flush with three outstanding requests.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'hF, 1'b1, 1'b0, 0, 1'b0);
         tick();
      end
      applyStimulus(4'h0, 1'b1, 1'b0, 0, 1'b1);
      tick();
      gotDone = 1'b0;
      for (int i = 0; i < 10 && !gotDone; i++) begin
         applyStimulus(4'hF, 1'b1, mCount > 0, int'($urandom_range(0, 3)), 1'b1);
         checkOutput("drainNoReady", 32'(bus.req_ready), 32'd0);
         if (flush_done) gotDone = 1'b1;
         tick();
      end
      checkOutput("flushDoneSeen", 32'(gotDone), 32'd1);
      applyStimulus(4'hF, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("doneHeld", 32'(flush_done), 32'd1);
      tick();
      applyStimulus(4'hF, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("flushReleased", 32'(flush_done), 32'd0);
      checkOutput("grantsResume", 32'(bus.mem_req_valid), 32'd1);
      tick();

      // Asynchronous reset in the middle of a cycle takes effect without a clock edge.
      applyStimulus(4'hF, 1'b1, 1'b0, 0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("asyncSize", 32'(pending_size), 32'd0);
      checkOutput("asyncEmpty", 32'(pending_empty), 32'd1);
      checkOutput("asyncFull", 32'(pending_full), 32'd0);
      checkOutput("asyncUnderflow", 32'(underflow_err), 32'd0);
      checkOutput("asyncFlushDone", 32'(flush_done), 32'd0);
      checkOutput("asyncGrantId", 32'(bus.mem_req_id), 32'd0);
      modelReset();
      @(posedge clk);
      #1;
      reset = 1'b1;

      // While the port is stalled, the grant stays on id 1. After it fires, id 3 is next.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b1010, 1'b0, 1'b0, 0, 1'b0);
         checkOutput("stallGrantId", 32'(bus.mem_req_id), 32'd1);
         tick();
      end
      applyStimulus(4'b1010, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("stallFire", 32'(bus.req_ready), 32'b0010);
      tick();
      applyStimulus(4'b1010, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("nextGrantId", 32'(bus.mem_req_id), 32'd3);
      tick();

      // Randomized traffic with occasional flush episodes.
      flushHold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (flushHold == 0 && $urandom_range(0, 40) == 0) flushHold = int'($urandom_range(1, 12));
         applyStimulus(4'($urandom), $urandom_range(0, 3) != 0,
                       (mCount > 0) && ($urandom_range(0, 1) == 1),
                       int'($urandom_range(0, 3)), flushHold > 0);
         if (flushHold > 0) flushHold--;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
